// File: rtl/counter_snapshot_tx.sv
// Snapshot both 64-bit event counters on Snap and stream them as a framed word sequence.
// Optional trailing XOR checksum word: define COUNTER_SNAPSHOT_CHECKSUM_EN.
module counter_snapshot_tx #(
    parameter int WORD_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Snap,
    input  logic [63:0]       Cnt0,
    input  logic [63:0]       Cnt1,
    output logic [WORD_W-1:0] TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              TxLast,
    output logic              Busy,
    output logic [7:0]        Seq,
    output logic [7:0]        DropCnt
);

    localparam int N_WORDS = 64 / WORD_W;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA0,
        DATA1
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
        ,
        CHK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [63:0]       shadow0_q, shadow0_d;
    logic [63:0]       shadow1_q, shadow1_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        drop_q, drop_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
    logic [WORD_W-1:0] chk_q, chk_d;
`endif

    logic        xfer;
    logic        frame_done;
    logic        accept;
    logic [63:0] word_sel;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow0_d  = shadow0_q;
        shadow1_d  = shadow1_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        frame_done = 1'b0;
        xfer       = valid_q & TxReady;
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
        chk_d      = xfer ? (chk_q ^ data_q) : chk_q;
`endif

        case (state_q)
            IDLE: ;
            HDR: begin
                if (xfer) begin
                    state_d = DATA0;
                    idx_d   = '0;
                end
            end
            DATA0: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DATA1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DATA1: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
                        state_d = CHK;
`else
                        frame_done = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            CHK: begin
                if (xfer) frame_done = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (frame_done) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
        end

        // A Snap landing on the final-word transfer starts the next frame with no gap
        accept = Snap & ((state_q == IDLE) | frame_done);
        if (accept) begin
            shadow0_d = Cnt0;
            shadow1_d = Cnt1;
            state_d   = HDR;
            idx_d     = '0;
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            chk_d     = '0;
`endif
        end else if (Snap && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        // Outputs are derived from the next state so they come straight out of flops
        valid_d  = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
        word_sel = (state_d == DATA1) ? shadow1_d : shadow0_d;
        data_d   = '0;
        case (state_d)
            HDR:          data_d[7:0] = seq_d;
            DATA0, DATA1: data_d = word_sel[int'(idx_d)*WORD_W +: WORD_W];
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            CHK:          data_d = chk_d;
`endif
            default:      data_d = '0;
        endcase
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
        last_d = (state_d == CHK);
`else
        last_d = (state_d == DATA1) && (idx_d == IDX_LAST);
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign TxData  = data_q;
    assign TxValid = valid_q;
    assign TxLast  = last_q;
    assign Busy    = busy_q;
    assign Seq     = seq_q;
    assign DropCnt = drop_q;

endmodule
